// File: rtl/pacman_pkg.sv
// Shared Pacman definitions: direction codes, button indices and the
// priority pick used when several presses land in the same cycle.
package pacman_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   localparam int NUM_BTN   = 4;
   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;

   // Fixed priority up > down > left > right; callers only use the result
   // when at least one event bit is set.
   function automatic dir_e pick_dir(input logic [NUM_BTN-1:0] ev);
      dir_e d;
      d = DIR_RIGHT;
      if (ev[BTN_UP])
         d = DIR_UP;
      else if (ev[BTN_DOWN])
         d = DIR_DOWN;
      else if (ev[BTN_LEFT])
         d = DIR_LEFT;
      return d;
   endfunction

endpackage

// File: rtl/dir_debounce_cell.sv
// One push-button: 2-flop synchroniser, strobe-gated debounce counter,
// stable level flop and a one-cycle rise event.
module debounce_cell
   import pacman_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 8,
   parameter int CNT_W          = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic strobe,
   input  logic raw,
   output logic stable,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICKS - 1);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt;
   logic             stable_q;
   logic             stable_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         cnt      <= '0;
         stable_q <= 1'b0;
         stable_d <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], raw};
         stable_d <= stable_q;
         if (strobe) begin
            // Any agreeing sample restarts the run of disagreeing samples.
            if (sync_q[1] == stable_q) begin
               cnt <= '0;
            end else if (cnt == CNT_MAX) begin
               stable_q <= ~stable_q;
               cnt      <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   assign stable = stable_q;
   assign rise   = stable_q & ~stable_d;

endmodule

// File: rtl/dir_debounce.sv
// Debounces the four direction buttons on the clk_1ms sampling strobe and
// offers the latest press to the movement controller as dir/dir_valid.
module dir_debounce
   import pacman_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 8,
   parameter int CNT_W          = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clk_1ms,
   input  logic [3:0]   btn,
   output logic [3:0]   btn_stable,
   output logic [1:0]   dir,
   output logic         dir_valid,
   input  logic         dir_ack
);

   logic [2:0]         tick_q;
   logic               strobe;
   logic [NUM_BTN-1:0] rise;
   logic [1:0]         dir_q;
   logic               valid_q;

   // clk_1ms is only ever sampled as data; bit 2 is the previous synced level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tick_q <= '0;
      else
         tick_q <= {tick_q[1:0], clk_1ms};
   end

   assign strobe = tick_q[1] & ~tick_q[2];

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
      debounce_cell #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
         .CNT_W          (CNT_W)
      ) u_cell (
         .clk    (clk),
         .rst_n  (rst_n),
         .strobe (strobe),
         .raw    (btn[i]),
         .stable (btn_stable[i]),
         .rise   (rise[i])
      );
   end

   // dir_valid/dir_ack: dir is held while dir_valid=1; a transfer happens on
   // a cycle with both high. A new press always loads and wins over the ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_q   <= DIR_UP;
         valid_q <= 1'b0;
      end else if (|rise) begin
         dir_q   <= pick_dir(rise);
         valid_q <= 1'b1;
      end else if (valid_q && dir_ack) begin
         valid_q <= 1'b0;
      end
   end

   assign dir       = dir_q;
   assign dir_valid = valid_q;

endmodule

// File: tb/tb_dir_debounce.sv
// Directed bench for dir_debounce: expected direction codes are queued when
// a press is driven and checked when the DUT announces a new direction.
module tb_dir_debounce;

   logic       clk;
   logic       rst_n;
   logic       clk_1ms;
   logic [3:0] btn;
   logic [3:0] btn_stable;
   logic [1:0] dir;
   logic       dir_valid;
   logic       dir_ack;

   int n_cmp = 0;
   int n_err = 0;

   logic [1:0] exp_q[$];
   logic       prev_valid = 1'b0;
   logic [1:0] prev_dir   = 2'd0;

   dir_debounce #(
      .DEBOUNCE_TICKS (8),
      .CNT_W          (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clk_1ms    (clk_1ms),
      .btn        (btn),
      .btn_stable (btn_stable),
      .dir        (dir),
      .dir_valid  (dir_valid),
      .dir_ack    (dir_ack)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // scoreboard: a new announcement is dir_valid rising or dir changing while valid
   always @(negedge clk) begin
      if (dir_valid && (!prev_valid || dir != prev_dir)) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL unexpected_event: observed dir %0d expected no event", dir);
         end else begin
            check("event_dir", 32'(dir), 32'(exp_q.pop_front()));
         end
      end
      prev_valid = dir_valid;
      prev_dir   = dir;
   end

   // driver tasks
   task automatic tick();
      clk_1ms = 1'b1;
      repeat (10) @(negedge clk);
      clk_1ms = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic tick_watch(input int bit_i, output int rise_idx, output int valid_idx);
      rise_idx  = -1;
      valid_idx = -1;
      clk_1ms   = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (rise_idx < 0 && btn_stable[bit_i]) rise_idx = i;
         if (valid_idx < 0 && dir_valid) valid_idx = i;
      end
      clk_1ms = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic ack_pulse();
      dir_ack = 1'b1;
      @(negedge clk);
      dir_ack = 1'b0;
      check("ack_clears_valid", 32'(dir_valid), 32'd0);
   endtask

   initial begin
      int r_idx;
      int v_idx;
      rst_n   = 1'b0;
      clk_1ms = 1'b0;
      btn     = 4'b0000;
      dir_ack = 1'b0;

      // reset then idle
      repeat (5) @(negedge clk);
      check("reset_stable", 32'(btn_stable), 32'h0);
      check("reset_dir", 32'(dir), 32'h0);
      check("reset_valid", 32'(dir_valid), 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_stable", 32'(btn_stable), 32'h0);
         check("idle_valid", 32'(dir_valid), 32'h0);
      end

      // clean left press: flip on the 8th strobe, valid one cycle later
      btn = 4'b0100;
      exp_q.push_back(2'd2);
      ticks(7);
      check("clean_pre_stable", 32'(btn_stable), 32'h0);
      check("clean_pre_valid", 32'(dir_valid), 32'h0);
      tick_watch(2, r_idx, v_idx);
      check("clean_stable_cycle", 32'(r_idx), 32'd3);
      check("clean_valid_cycle", 32'(v_idx), 32'd4);
      check("clean_dir", 32'(dir), 32'd2);
      ack_pulse();
      check("ack_dir_holds", 32'(dir), 32'd2);
      btn = 4'b0000;
      ticks(8);
      check("release_stable", 32'(btn_stable), 32'h0);
      check("release_no_event", 32'(dir_valid), 32'h0);

      // bounce on up: 5 high, 1 low, 8 high
      btn = 4'b0001;
      ticks(5);
      btn = 4'b0000;
      ticks(1);
      btn = 4'b0001;
      ticks(7);
      check("bounce_pre_stable", 32'(btn_stable), 32'h0);
      check("bounce_pre_valid", 32'(dir_valid), 32'h0);
      exp_q.push_back(2'd0);
      tick();
      check("bounce_stable", 32'(btn_stable), 32'h1);
      check("bounce_valid", 32'(dir_valid), 32'h1);
      ack_pulse();
      btn = 4'b0000;
      ticks(8);

      // simultaneous down + right: down wins
      btn = 4'b1010;
      exp_q.push_back(2'd1);
      ticks(8);
      check("simul_stable", 32'(btn_stable), 32'ha);
      check("simul_dir", 32'(dir), 32'd1);
      check("simul_valid", 32'(dir_valid), 32'h1);
      ack_pulse();
      btn = 4'b0000;
      ticks(8);

      // overwrite: up pending, then right overwrites
      btn = 4'b0001;
      exp_q.push_back(2'd0);
      ticks(8);
      check("ovw_first_dir", 32'(dir), 32'd0);
      btn = 4'b1001;
      exp_q.push_back(2'd3);
      ticks(8);
      check("ovw_dir", 32'(dir), 32'd3);
      check("ovw_valid", 32'(dir_valid), 32'h1);
      btn = 4'b1000;
      ticks(8);
      check("ovw_up_released", 32'(btn_stable), 32'h8);
      check("ovw_still_valid", 32'(dir_valid), 32'h1);

      // new up press in the same cycle as dir_ack: press wins
      btn = 4'b1001;
      ticks(7);
      exp_q.push_back(2'd0);
      clk_1ms = 1'b1;
      repeat (3) @(negedge clk);
      check("coll_stable", 32'(btn_stable), 32'h9);
      dir_ack = 1'b1;
      @(negedge clk);
      dir_ack = 1'b0;
      check("coll_dir", 32'(dir), 32'd0);
      check("coll_valid", 32'(dir_valid), 32'h1);
      repeat (6) @(negedge clk);
      clk_1ms = 1'b0;
      repeat (10) @(negedge clk);
      ack_pulse();
      btn = 4'b0000;
      ticks(8);

      // stuck clk_1ms: pending down press and stable levels freeze
      btn = 4'b0010;
      exp_q.push_back(2'd1);
      ticks(8);
      btn = 4'b0111;
      repeat (60) @(negedge clk);
      check("stuck_stable", 32'(btn_stable), 32'h2);
      check("stuck_valid", 32'(dir_valid), 32'h1);
      check("stuck_dir", 32'(dir), 32'd1);

      // reset mid-count with down+left held
      btn = 4'b0110;
      ticks(5);
      rst_n = 1'b0;
      #1;
      check("rst_mid_stable", 32'(btn_stable), 32'h0);
      check("rst_mid_dir", 32'(dir), 32'd0);
      check("rst_mid_valid", 32'(dir_valid), 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ticks(7);
      check("rst_pre_stable", 32'(btn_stable), 32'h0);
      check("rst_pre_valid", 32'(dir_valid), 32'h0);
      exp_q.push_back(2'd1);
      tick();
      check("rst_post_stable", 32'(btn_stable), 32'h6);
      check("rst_post_dir", 32'(dir), 32'd1);
      check("rst_post_valid", 32'(dir_valid), 32'h1);

      repeat (5) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
